mem_port_arbiter: RTL and testbench

//  Shares the CPU's single memory port between instruction fetch (I) and the LW/SW data path (D).

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for a single memory port with watchdog.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin on contention; default D wins).
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t              state_r, state_nxt_s;
  logic                owner_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [CNT_W-1:0]    wd_cnt_r;
  logic                if_valid_r, d_valid_r, timeout_r;
  logic [DATA_W-1:0]   if_rdata_r, d_rdata_r;
  logic                gnt_i_s, gnt_d_s, done_s, tmo_s, busy_s, wd_hit_s, d_prio_s;

  assign busy_s   = (state_r == BUSY_I) || (state_r == BUSY_D);
  assign wd_hit_s = (TIMEOUT_CYCLES != 0) && (wd_cnt_r == WD_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  assign d_prio_s = (owner_r == OWNER_I);
`else
  assign d_prio_s = 1'b1;
`endif

  // Next-state, grant and completion decode
  always_comb begin
    state_nxt_s = state_r;
    gnt_i_s     = 1'b0;
    gnt_d_s     = 1'b0;
    done_s      = 1'b0;
    tmo_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_req && (!if_req || d_prio_s)) begin
          gnt_d_s     = 1'b1;
          state_nxt_s = BUSY_D;
        end else if (if_req) begin
          gnt_i_s     = 1'b1;
          state_nxt_s = BUSY_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        // mem_ready takes precedence over a simultaneous watchdog hit
        if (mem_ready) begin
          done_s      = 1'b1;
          state_nxt_s = DONE;
        end else if (wd_hit_s) begin
          done_s      = 1'b1;
          tmo_s       = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Port payload latched on the grant edge; owner doubles as last_owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= OWNER_I;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (gnt_d_s) begin
      owner_r <= OWNER_D;
      we_r    <= d_we;
      addr_r  <= d_addr;
      wdata_r <= d_wdata;
    end else if (gnt_i_s) begin
      owner_r <= OWNER_I;
      we_r    <= 1'b0;
      addr_r  <= if_addr;
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      owner_r <= owner_r;
    end
  end

  // Watchdog: consecutive not-ready busy cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wd_cnt_r <= {CNT_W{1'b0}};
    else if (busy_s && !mem_ready) wd_cnt_r <= wd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    else                          wd_cnt_r <= {CNT_W{1'b0}};
  end

  // Completion outputs: one-cycle valid/timeout pulses with held read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_r <= 1'b0;
      d_valid_r  <= 1'b0;
      timeout_r  <= 1'b0;
      if_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r  <= {DATA_W{1'b0}};
    end else if (done_s) begin
      if_valid_r <= (owner_r == OWNER_I);
      d_valid_r  <= (owner_r == OWNER_D);
      timeout_r  <= tmo_s;
      if (owner_r == OWNER_I) begin
        if_rdata_r <= tmo_s ? {DATA_W{1'b0}} : mem_rdata;
      end else begin
        d_rdata_r  <= (tmo_s || we_r) ? {DATA_W{1'b0}} : mem_rdata;
      end
    end else begin
      if_valid_r <= 1'b0;
      d_valid_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end
  end

  assign if_gnt      = gnt_i_s;
  assign d_gnt       = gnt_d_s;
  assign if_valid    = if_valid_r;
  assign d_valid     = d_valid_r;
  assign if_rdata    = if_rdata_r;
  assign d_rdata     = d_rdata_r;
  assign timeout_err = timeout_r;
  assign mem_req     = busy_s;
  assign mem_we      = busy_s & we_r;
  assign mem_addr    = addr_r;
  assign mem_wdata   = wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (watchdog set to 8 cycles).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_valid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_gnt, d_valid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mutual exclusion of grants and completions
  always @(negedge clk) begin
    chk("gnt_excl", {31'd0, if_gnt & d_gnt}, 32'd0);
    chk("valid_excl", {31'd0, if_valid & d_valid}, 32'd0);
  end

  initial begin
    int n;
    logic [3:0] gseq;
    logic [3:0] gexp;
    int vcnt;

    // Reset state
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_valid", {30'd0, if_valid, d_valid}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Store with immediate ready
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFEF00D;
    #1;
    chk("st_gnt", {31'd0, d_gnt}, 32'd1);
    chk("st_if_gnt", {31'd0, if_gnt}, 32'd0);
    step();
    d_req = 1'b0; d_wdata = 32'h0;
    chk("st_mem_req", {31'd0, mem_req}, 32'd1);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_addr", mem_addr, 32'h100);
    chk("st_mem_wdata", mem_wdata, 32'hCAFEF00D);
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ready = 1'b0;
    chk("st_valid", {31'd0, d_valid}, 32'd1);
    chk("st_rdata", d_rdata, 32'd0);
    chk("st_mem_req_done", {31'd0, mem_req}, 32'd0);
    step();
    chk("st_valid_pulse", {31'd0, d_valid}, 32'd0);

    // Fetch with ready three cycles after mem_req rises
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    chk("f_gnt", {31'd0, if_gnt}, 32'd1);
    step();
    if_req = 1'b0; if_addr = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      chk("f_mem_req", {31'd0, mem_req}, 32'd1);
      chk("f_mem_addr", mem_addr, 32'h40);
      chk("f_mem_we", {31'd0, mem_we}, 32'd0);
      chk("f_no_valid", {31'd0, if_valid}, 32'd0);
      if (c == 3) begin
        mem_ready = 1'b1; mem_rdata = 32'h8C220004;
      end
      step();
    end
    mem_ready = 1'b0;
    chk("f_valid", {31'd0, if_valid}, 32'd1);
    chk("f_rdata", if_rdata, 32'h8C220004);
    chk("f_d_valid", {31'd0, d_valid}, 32'd0);
    step();

    // Contention over four accesses (last grant was I)
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
`ifdef ARB_ROUND_ROBIN_EN
    gexp = 4'b0101;
`else
    gexp = 4'b1111;
`endif
    gseq = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ct_one_gnt", {31'd0, if_gnt ^ d_gnt}, 32'd1);
      gseq[k] = d_gnt;
      step();
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      step();
    end
    chk("ct_seq", {28'd0, gseq}, {28'd0, gexp});
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Watchdog expiry
    if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'hDEADBEEF;
    step();
    if_req = 1'b0;
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      step();
    end
    chk("wd_req_cycles", n, 32'd8);
    chk("wd_tmo", {31'd0, timeout_err}, 32'd1);
    chk("wd_valid", {31'd0, if_valid}, 32'd1);
    chk("wd_rdata", if_rdata, 32'd0);
    step();
    chk("wd_tmo_pulse", {31'd0, timeout_err}, 32'd0);

    // Ready on the 8th cycle beats the watchdog
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_rdata = 32'h12345678;
    step();
    d_req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk("wd2_mem_req", {31'd0, mem_req}, 32'd1);
      step();
    end
    chk("wd2_mem_req8", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("wd2_valid", {31'd0, d_valid}, 32'd1);
    chk("wd2_rdata", d_rdata, 32'h12345678);
    chk("wd2_tmo", {31'd0, timeout_err}, 32'd0);
    step();

    // Data request arriving while fetch is busy
    if_req = 1'b1; if_addr = 32'h200;
    step();
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_rdata = 32'h0000_00AB;
    #1;
    chk("bz_no_gnt1", {31'd0, d_gnt}, 32'd0);
    step();
    chk("bz_no_gnt2", {31'd0, d_gnt}, 32'd0);
    chk("bz_addr", mem_addr, 32'h200);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("bz_if_valid", {31'd0, if_valid}, 32'd1);
    chk("bz_if_rdata", if_rdata, 32'h0000_00AB);
    chk("bz_no_gnt3", {31'd0, d_gnt}, 32'd0);
    step();
    chk("bz_gnt", {31'd0, d_gnt}, 32'd1);
    step();
    d_req = 1'b0;
    chk("bz_d_addr", mem_addr, 32'h300);
    mem_rdata = 32'h5555_AAAA; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("bz_d_valid", {31'd0, d_valid}, 32'd1);
    chk("bz_d_rdata", d_rdata, 32'h5555_AAAA);
    step();

    // Reset in the middle of an access
    if_req = 1'b1; if_addr = 32'h500;
    step();
    if_req = 1'b0;
    chk("mr_busy", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mr_mem_addr", mem_addr, 32'd0);
    chk("mr_rdata", if_rdata | d_rdata, 32'd0);
    step();
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (mem_req || if_valid || d_valid) vcnt++;
    end
    chk("mr_quiet", vcnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout: got=stuck expected=finish");
    $fatal(1);
  end

endmodule
